// File: rtl/mult_pkg.sv
// Shared definitions for the radix-4 multiplier load-protocol initiator.
// Holds the feeder state encoding, the chunk transfer order and the default
// half-word width used by mult_operand_feeder and its helpers.
package mult_pkg;

  localparam int HALF_W_DEF = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    KICK     = 3'd1,
    SETUP    = 3'd2,
    STROBE   = 3'd3,
    RELEASE  = 3'd4,
    WAIT_RDY = 3'd5,
    DONE     = 3'd6
  } feed_state_e;

  // Order in which operand halves are sent to the multiplier.
  localparam logic [1:0] CH_A_LSB = 2'd0;
  localparam logic [1:0] CH_A_MSB = 2'd1;
  localparam logic [1:0] CH_B_LSB = 2'd2;
  localparam logic [1:0] CH_B_MSB = 2'd3;

endpackage

// File: rtl/feed_cycle_counter.sv
// Small up-counter used to time phases of the feeder.
// Ports:
//   clk, rst   - clock, asynchronous active-low reset
//   clr        - synchronous clear to zero (highest priority)
//   ld, ld_val - synchronous load of an arbitrary start value
//   en         - count enable
//   tc         - high while the count equals TERM
module feed_cycle_counter #(
  parameter int W    = 4,
  parameter int TERM = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (ld) begin
      cnt_d = ld_val;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == W'(TERM));

endmodule

// File: rtl/mult_operand_feeder.sv
// Initiator side of the radix-4 multiplier start/get load protocol.
// Accepts an operand pair, launches the multiplier with a one-cycle low
// start, streams A-lsb, A-msb, B-lsb, B-msb on data_out (each strobed by get),
// then waits for the multiplier's ready pulse and holds the product.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high (op_valid/op_ready upstream, res_valid/res_ready downstream);
// valid does not depend on ready, and the offered data must stay stable while
// valid is high and ready is low.
//
// Ports:
//   clk, rst              - clock, asynchronous active-low reset
//   op_valid/op_ready     - operand handshake, op_a/op_b the operands
//   start, get, data_out  - registered load interface to the multiplier
//   ready, prod_in        - product-valid pulse and product from multiplier
//   res_valid/res_ready   - result handshake, res_prod the captured product
//   err_timeout           - one-cycle pulse when ready never arrived
//   busy                  - high whenever the feeder is not idle
//   dbg_state             - current FSM state
module mult_operand_feeder
  import mult_pkg::*;
#(
  parameter int HALF_W  = HALF_W_DEF,
  parameter int GET_CYC = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                op_valid,
  input  logic [2*HALF_W-1:0] op_a,
  input  logic [2*HALF_W-1:0] op_b,
  output logic                op_ready,
  output logic                start,
  output logic                get,
  output logic [HALF_W-1:0]   data_out,
  input  logic                ready,
  input  logic [4*HALF_W-1:0] prod_in,
  output logic                res_valid,
  output logic [4*HALF_W-1:0] res_prod,
  input  logic                res_ready,
  output logic                err_timeout,
  output logic                busy,
  output logic [2:0]          dbg_state
);

  localparam int OP_W = 2 * HALF_W;
  localparam int PR_W = 4 * HALF_W;
  localparam int GC_W = $clog2(GET_CYC + 1);
  localparam int TO_W = $clog2(TIMEOUT + 1);

  feed_state_e       state_q, state_d;
  logic [OP_W-1:0]   a_q, a_d, b_q, b_d;
  logic [1:0]        idx_q, idx_d;
  logic [HALF_W-1:0] data_out_q, data_out_d;
  logic [PR_W-1:0]   res_prod_q, res_prod_d;
  logic              err_d;
  logic              start_q, get_q, op_ready_q, busy_q, res_valid_q, err_q;
  logic              get_tc, to_tc;

  // Both counters sit at zero until their phase starts, so the first cycle
  // of STROBE / WAIT_RDY sees count 0 and tc marks the last cycle.
  feed_cycle_counter #(.W(GC_W), .TERM(GET_CYC - 1)) u_get_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q != STROBE),
    .ld     (1'b0),
    .ld_val ({GC_W{1'b0}}),
    .en     (1'b1),
    .tc     (get_tc)
  );

  feed_cycle_counter #(.W(TO_W), .TERM(TIMEOUT - 1)) u_to_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q != WAIT_RDY),
    .ld     (1'b0),
    .ld_val ({TO_W{1'b0}}),
    .en     (1'b1),
    .tc     (to_tc)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    idx_d      = idx_q;
    data_out_d = data_out_q;
    res_prod_d = res_prod_q;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          idx_d   = CH_A_LSB;
          state_d = KICK;
        end
      end
      KICK:    state_d = SETUP;
      SETUP:   state_d = STROBE;
      STROBE:  if (get_tc) state_d = RELEASE;
      RELEASE: begin
        if (idx_q == CH_B_MSB) begin
          state_d = WAIT_RDY;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = SETUP;
        end
      end
      WAIT_RDY: begin
        // ready wins over an expiring timeout in the same cycle.
        if (ready) begin
          res_prod_d = prod_in;
          state_d    = DONE;
        end else if (to_tc) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The chunk is loaded as SETUP is entered so data_out leads get by a cycle.
    if (state_d == SETUP) begin
      case (idx_d)
        CH_A_LSB: data_out_d = a_q[HALF_W-1:0];
        CH_A_MSB: data_out_d = a_q[OP_W-1:HALF_W];
        CH_B_LSB: data_out_d = b_q[HALF_W-1:0];
        default:  data_out_d = b_q[OP_W-1:HALF_W];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= CH_A_LSB;
      data_out_q  <= '0;
      res_prod_q  <= '0;
      start_q     <= 1'b1;
      get_q       <= 1'b0;
      op_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      idx_q       <= idx_d;
      data_out_q  <= data_out_d;
      res_prod_q  <= res_prod_d;
      // Outputs are decoded from the next state so they line up with state_q.
      start_q     <= (state_d != KICK);
      get_q       <= (state_d == STROBE);
      op_ready_q  <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
      res_valid_q <= (state_d == DONE);
      err_q       <= err_d;
    end
  end

  assign start       = start_q;
  assign get         = get_q;
  assign data_out    = data_out_q;
  assign op_ready    = op_ready_q;
  assign busy        = busy_q;
  assign res_valid   = res_valid_q;
  assign res_prod    = res_prod_q;
  assign err_timeout = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mult_operand_feeder.sv
module tb_mult_operand_feeder;

  localparam int HW = 4;
  localparam int GC = 2;
  localparam int TO = 8;
  // Accept edge to first WAIT_RDY cycle.
  localparam int XFER = 1 + 4 * (GC + 2);

  logic          clk = 1'b0;
  logic          rst;
  logic          op_valid;
  logic [2*HW-1:0] op_a, op_b;
  logic          op_ready;
  logic          start, get;
  logic [HW-1:0] data_out;
  logic          ready;
  logic [4*HW-1:0] prod_in;
  logic          res_valid;
  logic [4*HW-1:0] res_prod;
  logic          res_ready;
  logic          err_timeout;
  logic          busy;
  logic [2:0]    dbg_state;

  int errors = 0;
  int checks = 0;
  logic [HW-1:0] exp_q[$];
  logic [HW-1:0] got_q[$];

  mult_operand_feeder #(.HALF_W(HW), .GET_CYC(GC), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .op_valid    (op_valid),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_ready    (op_ready),
    .start       (start),
    .get         (get),
    .data_out    (data_out),
    .ready       (ready),
    .prod_in     (prod_in),
    .res_valid   (res_valid),
    .res_prod    (res_prod),
    .res_ready   (res_ready),
    .err_timeout (err_timeout),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver / checker tasks ----------------
  task automatic test_reset();
    rst = 1'b0; op_valid = 1'b0; op_a = '0; op_b = '0;
    ready = 1'b0; prod_in = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({start, get, op_ready, res_valid, err_timeout, busy} !== 6'b101000) begin
      errors++;
      $display("FAIL reset_ctrl: start/get/op_ready/res_valid/err/busy got %b want 101000",
               {start, get, op_ready, res_valid, err_timeout, busy});
    end
    checks++;
    if (data_out !== '0 || res_prod !== '0) begin
      errors++;
      $display("FAIL reset_data: data_out=%h res_prod=%h want 0/0", data_out, res_prod);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Runs one full operand load. Caller is at a negedge with the DUT idle.
  // rdy_at: WAIT_RDY cycle index (0..TO-1) in which ready pulses, -1 = never.
  // stray_at: transfer-phase sample index after which a stray ready pulses.
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input int rdy_at,
                         input int stray_at, input int hold, input string tag);
    logic [15:0]   exp_prod;
    int            start_low;
    logic          prev_get;
    int            run_len;
    logic [HW-1:0] run_data;

    exp_prod = {8'h00, a} * {8'h00, b};
    exp_q.delete();
    got_q.delete();
    exp_q.push_back(a[3:0]);
    exp_q.push_back(a[7:4]);
    exp_q.push_back(b[3:0]);
    exp_q.push_back(b[7:4]);

    checks++;
    if (op_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_before: op_ready=%b busy=%b want 1/0", tag, op_ready, busy);
    end
    op_valid = 1'b1; op_a = a; op_b = b;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0; op_a = 8'($urandom); op_b = 8'($urandom);

    start_low = 0; prev_get = 1'b0; run_len = 0; run_data = '0;
    for (int n = 0; n < XFER; n++) begin
      if (n > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      if (!start) start_low++;
      checks++;
      if ({busy, op_ready, res_valid, err_timeout} !== 4'b1000) begin
        errors++;
        $display("FAIL %s xfer_status n=%0d: busy/op_ready/res_valid/err got %b want 1000",
                 tag, n, {busy, op_ready, res_valid, err_timeout});
      end
      if (get && !prev_get) begin
        got_q.push_back(data_out);
        run_len = 1;
        run_data = data_out;
      end else if (get) begin
        run_len++;
        checks++;
        if (data_out !== run_data) begin
          errors++;
          $display("FAIL %s data_stable n=%0d: got %h want %h", tag, n, data_out, run_data);
        end
      end else if (prev_get) begin
        checks++;
        if (run_len != GC || data_out !== run_data) begin
          errors++;
          $display("FAIL %s get_width n=%0d: high %0d cycles data %h, want %0d cycles data %h",
                   tag, n, run_len, data_out, GC, run_data);
        end
      end
      prev_get = get;
      ready = (n == stray_at);
      prod_in = 16'($urandom);
    end

    checks++;
    if (start_low != 1) begin
      errors++;
      $display("FAIL %s start_pulse: start low %0d cycles want 1", tag, start_low);
    end
    checks++;
    if (got_q.size() != 4) begin
      errors++;
      $display("FAIL %s chunk_count: got %0d want 4", tag, got_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got_q[k] !== exp_q[k]) begin
          errors++;
          $display("FAIL %s chunk%0d: got %h want %h", tag, k, got_q[k], exp_q[k]);
        end
      end
    end

    // Wait for ready phase; j counts samples after WAIT_RDY entry.
    for (int j = 0; j < TO + 2; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (rdy_at >= 0 && j == rdy_at + 1) begin
        checks++;
        if (res_valid !== 1'b1 || res_prod !== exp_prod || err_timeout !== 1'b0 || op_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s capture: res_valid=%b res_prod=%h err=%b op_ready=%b want 1/%h/0/0",
                   tag, res_valid, res_prod, err_timeout, op_ready, exp_prod);
        end
        ready = 1'b0;
        break;
      end else if (rdy_at < 0 && j == TO) begin
        checks++;
        if ({err_timeout, res_valid, op_ready, busy} !== 4'b1010) begin
          errors++;
          $display("FAIL %s timeout_pulse: err/res_valid/op_ready/busy got %b want 1010",
                   tag, {err_timeout, res_valid, op_ready, busy});
        end
      end else if (rdy_at < 0 && j == TO + 1) begin
        checks++;
        if ({err_timeout, res_valid, op_ready, busy} !== 4'b0010) begin
          errors++;
          $display("FAIL %s timeout_after: err/res_valid/op_ready/busy got %b want 0010",
                   tag, {err_timeout, res_valid, op_ready, busy});
        end
        break;
      end else begin
        checks++;
        if ({res_valid, err_timeout, busy, get, start} !== 5'b00101) begin
          errors++;
          $display("FAIL %s wait_status j=%0d: res_valid/err/busy/get/start got %b want 00101",
                   tag, j, {res_valid, err_timeout, busy, get, start});
        end
      end
      ready = (j == rdy_at);
      prod_in = ready ? exp_prod : 16'($urandom);
    end
    ready = 1'b0;

    if (rdy_at >= 0) begin
      // Offer a new operand while the result is held; it must be ignored.
      op_valid = 1'b1; op_a = 8'($urandom); op_b = 8'($urandom);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk);
        @(negedge clk);
        ready = ($urandom_range(0, 1) == 1);
        prod_in = 16'($urandom);
        checks++;
        if (res_valid !== 1'b1 || res_prod !== exp_prod || op_ready !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL %s hold h=%0d: res_valid=%b res_prod=%h op_ready=%b busy=%b want 1/%h/0/1",
                   tag, h, res_valid, res_prod, op_ready, busy, exp_prod);
        end
      end
      ready = 1'b0;
      op_valid = 1'b0;
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      res_ready = 1'b0;
      checks++;
      if (res_valid !== 1'b0 || op_ready !== 1'b1 || busy !== 1'b0 || res_prod !== exp_prod) begin
        errors++;
        $display("FAIL %s release: res_valid=%b op_ready=%b busy=%b res_prod=%h want 0/1/0/%h",
                 tag, res_valid, op_ready, busy, res_prod, exp_prod);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || start !== 1'b1) begin
        errors++;
        $display("FAIL %s nothing_queued: busy=%b start=%b want 0/1", tag, busy, start);
      end
    end
  endtask

  task automatic test_basic();
    run_txn(8'hA5, 8'h3C, 2, -1, 0, "basic");
  endtask

  task automatic test_back_pressure();
    run_txn(8'hA5, 8'h3C, 0, -1, 10, "backpressure");
  endtask

  task automatic test_timeout();
    run_txn(8'h5A, 8'hC3, -1, -1, 0, "timeout");
  endtask

  task automatic test_stray_ready();
    // Sample 10 is the first STROBE cycle of chunk 2.
    run_txn(8'h01, 8'h01, 3, 10, 1, "stray");
  endtask

  task automatic test_reset_mid();
    op_valid = 1'b1; op_a = 8'h96; op_b = 8'h69;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    // Advance to the first STROBE cycle of chunk 1.
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (get !== 1'b1 || data_out !== 4'h9) begin
      errors++;
      $display("FAIL rstmid_pre: get=%b data_out=%h want 1/9", get, data_out);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({get, start, busy, op_ready, res_valid, err_timeout} !== 6'b010100) begin
      errors++;
      $display("FAIL rstmid_abort: get/start/busy/op_ready/res_valid/err got %b want 010100",
               {get, start, busy, op_ready, res_valid, err_timeout});
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, op_ready, err_timeout, res_valid} !== 4'b0100) begin
      errors++;
      $display("FAIL rstmid_idle: busy/op_ready/err/res_valid got %b want 0100",
               {busy, op_ready, err_timeout, res_valid});
    end
    run_txn(8'hFF, 8'hFF, 1, -1, 0, "after_reset");
  endtask

  task automatic test_edge_timing();
    run_txn(8'h37, 8'hE2, TO - 1, -1, 0, "edge_expiry");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      run_txn(8'($urandom), 8'($urandom), int'($urandom_range(0, TO - 1)),
              int'($urandom_range(1, XFER - 1)), int'($urandom_range(0, 3)), "random");
    end
    run_txn(8'($urandom), 8'($urandom), -1, 5, 0, "random_timeout");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_back_pressure();
    test_timeout();
    test_stray_ready();
    test_reset_mid();
    test_edge_timing();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
